// File: rtl/tri_rast_sequencer.sv
// tri_fifo: small first-word-fall-through FIFO used for the assembled-triangle queue.
// Latency: a write is visible at rd_dat / rd_vld the following cycle.
// Backpressure: rd_rdy pops the head; the writer must never push when full (no guard here).
// Ports: clk, rst (sync, active-high); wr_vld/wr_dat push side; rd_vld/rd_rdy/rd_dat pop side.
module tri_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             rd_vld,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [NW-1:0]    count;
  logic             rd;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rd_vld = (count != '0);
  assign rd_dat = mem[rd_ptr];
  assign rd     = rd_vld && rd_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // Storage is cleared so the head reads as zero straight out of reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_vld) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (rd) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_vld, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// tri_rast_sequencer: issues a triangle's three vertices to a vertex rasterizer and reassembles the returns with a bounding box.
// Latency: accept at T issues at T+1..T+3; out_valid rises the cycle after the third return is counted.
// Backpressure: tri_ready requires a reserved output-FIFO credit, so the FIFO never overflows; out_ready pops and frees a credit.
// Ports: clk/rst; tri_valid/tri_ready/tri_ndc/tri_vertex_3d upstream; vr_valid/vr_ndc_pt/vr_vertex_3d issue;
//        vr_rast_pt/vr_rast_pt_valid returns; out_valid/out_ready/out_pts/out_bbox downstream; err_orphan sticky error.
//        Vector element [0] is x. out_bbox[0..3] = min_x, min_y, max_x, max_y (signed).
module tri_rast_sequencer #(
  parameter int TRI_FIFO_DEPTH = 2,
  parameter int DRAIN_CYCLES   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tri_valid,
  output logic                  tri_ready,
  input  logic [2:0][1:0][15:0] tri_ndc,
  input  logic [2:0][2:0][15:0] tri_vertex_3d,
  output logic                  vr_valid,
  output logic [1:0][15:0]      vr_ndc_pt,
  output logic [2:0][15:0]      vr_vertex_3d,
  input  logic [2:0][12:0]      vr_rast_pt,
  input  logic                  vr_rast_pt_valid,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2:0][2:0][12:0] out_pts,
  output logic [3:0][12:0]      out_bbox,
  output logic                  err_orphan
);
  localparam int CW = $clog2(TRI_FIFO_DEPTH + 1);
  localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam int IW = $clog2(3 * TRI_FIFO_DEPTH + 2);

  typedef enum logic [1:0] {IDLE, ISSUE0, ISSUE1, ISSUE2} state_t;

  state_t           state;
  logic [CW-1:0]    credits;
  logic [DW-1:0]    drain_cnt;
  logic [IW-1:0]    inflight;
  logic [1:0]       ret_idx;
  logic [2:0][12:0] stg0, stg1;
  logic [1:0][15:0] lat_ndc1, lat_ndc2;
  logic [2:0][15:0] lat_v1, lat_v2;

  logic draining, accept, pop, ret, ret_ok, push;
  logic [2:0][2:0][12:0] push_pts;
  logic [3:0][12:0]      push_bbox;
  logic [13*13-1:0]      fifo_dat;

  function automatic logic [12:0] smin(input logic [12:0] a, input logic [12:0] b);
    return ($signed(a) < $signed(b)) ? a : b;
  endfunction
  function automatic logic [12:0] smax(input logic [12:0] a, input logic [12:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  assign draining  = (drain_cnt != '0);
  assign tri_ready = ((state == IDLE) || (state == ISSUE2)) && (credits != '0) && !draining;
  assign accept    = tri_valid && tri_ready;
  assign pop       = out_valid && out_ready;
  // Returns during the post-reset drain belong to an abandoned triangle: dropped silently.
  assign ret       = vr_rast_pt_valid && !draining;
  assign ret_ok    = ret && (inflight != '0);
  assign push      = ret_ok && (ret_idx == 2'd2);

  assign push_pts     = {vr_rast_pt, stg1, stg0};
  assign push_bbox[0] = smin(smin(stg0[0], stg1[0]), vr_rast_pt[0]);
  assign push_bbox[1] = smin(smin(stg0[1], stg1[1]), vr_rast_pt[1]);
  assign push_bbox[2] = smax(smax(stg0[0], stg1[0]), vr_rast_pt[0]);
  assign push_bbox[3] = smax(smax(stg0[1], stg1[1]), vr_rast_pt[1]);

  // Issue FSM; vertex 0 goes straight to the outputs on accept, 1 and 2 are held for the next cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      vr_valid     <= 1'b0;
      vr_ndc_pt    <= '0;
      vr_vertex_3d <= '0;
      lat_ndc1     <= '0;
      lat_ndc2     <= '0;
      lat_v1       <= '0;
      lat_v2       <= '0;
    end else begin
      case (state)
        ISSUE0: begin
          vr_ndc_pt    <= lat_ndc1;
          vr_vertex_3d <= lat_v1;
          state        <= ISSUE1;
        end
        ISSUE1: begin
          vr_ndc_pt    <= lat_ndc2;
          vr_vertex_3d <= lat_v2;
          state        <= ISSUE2;
        end
        default: begin  // IDLE and ISSUE2 share the accept decision
          if (accept) begin
            lat_ndc1     <= tri_ndc[1];
            lat_ndc2     <= tri_ndc[2];
            lat_v1       <= tri_vertex_3d[1];
            lat_v2       <= tri_vertex_3d[2];
            vr_ndc_pt    <= tri_ndc[0];
            vr_vertex_3d <= tri_vertex_3d[0];
            vr_valid     <= 1'b1;
            state        <= ISSUE0;
          end else begin
            vr_valid <= 1'b0;
            state    <= IDLE;
          end
        end
      endcase
    end
  end

  // Credits, drain timer, in-flight tracking and return collector.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits    <= CW'(TRI_FIFO_DEPTH);
      drain_cnt  <= DW'(DRAIN_CYCLES);
      inflight   <= '0;
      ret_idx    <= '0;
      stg0       <= '0;
      stg1       <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (draining) drain_cnt <= drain_cnt - 1'b1;

      case ({accept, pop})
        2'b10: if (credits != '0) credits <= credits - 1'b1;
        2'b01: if (credits != CW'(TRI_FIFO_DEPTH)) credits <= credits + 1'b1;
        default: credits <= credits;
      endcase

      case ({vr_valid, ret_ok})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase

      if (ret_ok) begin
        if (ret_idx == 2'd0) stg0 <= vr_rast_pt;
        if (ret_idx == 2'd1) stg1 <= vr_rast_pt;
        ret_idx <= (ret_idx == 2'd2) ? 2'd0 : ret_idx + 1'b1;
      end

      if (ret && (inflight == '0)) err_orphan <= 1'b1;
    end
  end

  tri_fifo #(
    .WIDTH(13 * 13),
    .DEPTH(TRI_FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (push),
    .wr_dat ({push_pts, push_bbox}),
    .rd_vld (out_valid),
    .rd_rdy (out_ready),
    .rd_dat (fifo_dat)
  );

  assign {out_pts, out_bbox} = fifo_dat;
endmodule

// File: tb/tb_tri_rast_sequencer.sv
// Bench for tri_rast_sequencer: emulates the vertex rasterizer with random ordered latencies and
// scoreboards assembled triangles against bounding boxes computed with plain integer arithmetic.
module tb_tri_rast_sequencer;
  localparam int DEPTH = 2;
  localparam int DRAIN = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst = 1'b1;
  logic                  tri_valid = 1'b0;
  logic                  tri_ready;
  logic [2:0][1:0][15:0] tri_ndc = '0;
  logic [2:0][2:0][15:0] tri_vertex_3d = '0;
  logic                  vr_valid;
  logic [1:0][15:0]      vr_ndc_pt;
  logic [2:0][15:0]      vr_vertex_3d;
  logic [2:0][12:0]      vr_rast_pt = '0;
  logic                  vr_rast_pt_valid = 1'b0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [2:0][2:0][12:0] out_pts;
  logic [3:0][12:0]      out_bbox;
  logic                  err_orphan;

  tri_rast_sequencer #(.TRI_FIFO_DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst(rst),
    .tri_valid(tri_valid), .tri_ready(tri_ready),
    .tri_ndc(tri_ndc), .tri_vertex_3d(tri_vertex_3d),
    .vr_valid(vr_valid), .vr_ndc_pt(vr_ndc_pt), .vr_vertex_3d(vr_vertex_3d),
    .vr_rast_pt(vr_rast_pt), .vr_rast_pt_valid(vr_rast_pt_valid),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pts(out_pts), .out_bbox(out_bbox),
    .err_orphan(err_orphan)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state
  logic [79:0]  exp_vtx[$];   // {ndc, vertex_3d} per vertex, in issue order
  logic [168:0] exp_out[$];   // {pts, bbox} per triangle
  int           pend_due[$];
  logic [38:0]  pend_val[$];
  logic [38:0]  force_q[$];
  logic [38:0]  partial[$];
  int outstanding = 0, since_acc = 99, last_due = 0, ret3_cyc = -1;
  int lat_min = 1, lat_max = 4;
  int acc_count = 0, pop_count = 0;
  bit rast_en = 1'b0, ret_auto = 1'b0, acc_seen = 1'b0;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [38:0] v3(input int x, input int y, input int z);
    return {13'(z), 13'(y), 13'(x)};
  endfunction

  function automatic logic [168:0] make_tri(input logic [38:0] p0, input logic [38:0] p1, input logic [38:0] p2);
    int xs[3], ys[3];
    int mnx, mny, mxx, mxy;
    xs[0] = $signed(p0[12:0]); ys[0] = $signed(p0[25:13]);
    xs[1] = $signed(p1[12:0]); ys[1] = $signed(p1[25:13]);
    xs[2] = $signed(p2[12:0]); ys[2] = $signed(p2[25:13]);
    mnx = xs[0]; mxx = xs[0]; mny = ys[0]; mxy = ys[0];
    for (int k = 1; k < 3; k++) begin
      if (xs[k] < mnx) mnx = xs[k];
      if (xs[k] > mxx) mxx = xs[k];
      if (ys[k] < mny) mny = ys[k];
      if (ys[k] > mxy) mxy = ys[k];
    end
    return {p2, p1, p0, 13'(mxy), 13'(mxx), 13'(mny), 13'(mnx)};
  endfunction

  task automatic rand_tri();
    for (int k = 0; k < 3; k++) begin
      tri_ndc[k]       = $urandom();
      tri_vertex_3d[k] = 48'({$urandom(), $urandom()});
    end
  endtask

  // Sampled at the falling edge, where inputs and outputs of the current cycle are stable.
  task automatic monitor();
    bit acc;
    int due;
    logic [79:0] e;
    acc = tri_valid && tri_ready;
    acc_seen = 1'b0;
    if (rst) return;
    if (since_acc == 1 || since_acc == 2) chk("rdy_in_issue", tri_ready, 0);
    if (outstanding >= DEPTH) chk("rdy_no_credit", tri_ready, 0);
    if (acc) begin
      for (int k = 0; k < 3; k++) exp_vtx.push_back({tri_ndc[k], tri_vertex_3d[k]});
      outstanding++;
      acc_count++;
      since_acc = 0;
      acc_seen = 1'b1;
    end
    since_acc++;
    if (vr_valid) begin
      if (exp_vtx.size() == 0) chk("vr_unexpected", vr_valid, 0);
      else begin
        e = exp_vtx.pop_front();
        chk("vr_ops", {vr_ndc_pt, vr_vertex_3d}, e);
      end
      if (rast_en) begin
        due = cyc + $urandom_range(lat_max, lat_min);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend_due.push_back(due);
        if (force_q.size() > 0) pend_val.push_back(force_q.pop_front());
        else pend_val.push_back(39'({$urandom(), $urandom()}));
      end
    end
    if (vr_rast_pt_valid && ret_auto) begin
      partial.push_back(vr_rast_pt);
      if (partial.size() == 3) begin
        exp_out.push_back(make_tri(partial[0], partial[1], partial[2]));
        partial.delete();
        ret3_cyc = cyc;
      end
    end
    if (out_valid && out_ready) begin
      pop_count++;
      outstanding--;
      if (exp_out.size() == 0) chk("out_unexpected", out_valid, 0);
      else chk("out_tri", {out_pts, out_bbox}, exp_out.pop_front());
    end
  endtask

  // One clock: check the current cycle, then drive rasterizer returns for the next one.
  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
    if (pend_due.size() > 0 && pend_due[0] == cyc) begin
      vr_rast_pt       = pend_val.pop_front();
      pend_due.delete(0);
      vr_rast_pt_valid = 1'b1;
      ret_auto         = 1'b1;
    end else begin
      vr_rast_pt_valid = 1'b0;
      ret_auto         = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; tri_valid = 1'b0; out_ready = 1'b0; rast_en = 1'b0;
    exp_vtx.delete(); exp_out.delete(); pend_due.delete(); pend_val.delete();
    force_q.delete(); partial.delete();
    outstanding = 0; since_acc = 99; last_due = 0;
    cycle();
    chk("rst_tri_ready", tri_ready, 0);
    chk("rst_vr_valid", vr_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err_orphan", err_orphan, 0);
    chk("rst_out_pts", out_pts, 0);
    chk("rst_out_bbox", out_bbox, 0);
    chk("rst_vr_ops", {vr_ndc_pt, vr_vertex_3d}, 0);
    cycle();
    rst = 1'b0;
  endtask

  task automatic drain(input bit inject);
    for (int i = 0; i < DRAIN; i++) begin
      chk("drain_rdy", tri_ready, 0);
      chk("drain_out_valid", out_valid, 0);
      chk("drain_err", err_orphan, 0);
      if (inject && (i == 1 || i == 3 || i == 5)) begin
        vr_rast_pt       = v3(i, -i, 3);
        vr_rast_pt_valid = 1'b1;
      end
      cycle();
    end
    chk("drain_end_rdy", tri_ready, 1);
  endtask

  task automatic idle(input int n);
    tri_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int n0, p0, vrun, vmax;

    // Single triangle with the known returns
    do_reset();
    drain(1'b0);
    rast_en = 1'b1; lat_min = 2; lat_max = 2; out_ready = 1'b1;
    force_q.push_back(v3(10, 20, 5));
    force_q.push_back(v3(-3, 40, 6));
    force_q.push_back(v3(7, -8, 7));
    rand_tri();
    tri_valid = 1'b1;
    cycle();
    chk("t1_accepted", acc_seen, 1);
    tri_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) break;
      cycle();
    end
    chk("t1_out_valid", out_valid, 1);
    chk("t1_latency", cyc, ret3_cyc + 1);
    chk("t1_pts", out_pts, {v3(7, -8, 7), v3(-3, 40, 6), v3(10, 20, 5)});
    chk("t1_bbox", out_bbox, {13'(40), 13'(10), 13'(-8), 13'(-3)});
    idle(10);

    // Four back-to-back triangles with a one-cycle rasterizer
    lat_min = 1; lat_max = 1;
    n0 = acc_count; p0 = pop_count; vrun = 0; vmax = 0;
    rand_tri();
    tri_valid = 1'b1; acc_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (acc_count - n0 >= 4) tri_valid = 1'b0;
      else if (acc_seen) rand_tri();
      if (vr_valid) vrun++; else vrun = 0;
      if (vrun > vmax) vmax = vrun;
      cycle();
    end
    chk("b2b_vr_run", vmax, 12);
    chk("b2b_outputs", pop_count - p0, 4);

    // Output stalled: only the FIFO depth worth of triangles gets in
    lat_min = 1; lat_max = 4; out_ready = 1'b0;
    n0 = acc_count;
    rand_tri();
    tri_valid = 1'b1; acc_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (acc_seen) rand_tri();
      cycle();
    end
    chk("bp_accepts", acc_count - n0, DEPTH);
    chk("bp_rdy_low", tri_ready, 0);
    chk("bp_head_valid", out_valid, 1);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (acc_seen) rand_tri();
      cycle();
    end
    chk("bp_one_more", acc_count - n0, DEPTH + 1);
    chk("bp_rdy_low2", tri_ready, 0);
    idle(60);
    chk("bp_flushed", outstanding, 0);

    // Orphan return
    do_reset();
    drain(1'b0);
    vr_rast_pt = v3(1, 2, 3);
    vr_rast_pt_valid = 1'b1;
    cycle();
    for (int i = 0; i < 8; i++) begin
      chk("orphan_sticky", err_orphan, 1);
      chk("orphan_no_out", out_valid, 0);
      cycle();
    end

    // Reset between the second and third issue, late returns during drain
    do_reset();
    drain(1'b0);
    rand_tri();
    tri_valid = 1'b1;
    cycle();
    tri_valid = 1'b0;
    cycle();
    chk("mid_issue1", vr_valid, 1);
    do_reset();
    drain(1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("mid_no_out", out_valid, 0);
      chk("mid_no_err", err_orphan, 0);
      cycle();
    end

    // Randomized traffic
    do_reset();
    drain(1'b0);
    rast_en = 1'b1; lat_min = 1; lat_max = 4;
    acc_seen = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (!tri_valid || acc_seen) begin
        tri_valid = ($urandom_range(99, 0) < 70);
        rand_tri();
      end
      out_ready = ($urandom_range(99, 0) < 60);
      cycle();
    end
    idle(80);
    chk("end_out_q", exp_out.size(), 0);
    chk("end_vtx_q", exp_vtx.size(), 0);
    chk("end_outstanding", outstanding, 0);
    chk("end_err", err_orphan, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
